// File: rtl/int_req_ctrl.sv
// rtl/int_req_ctrl.sv - external interrupt request front-end
// Synchronizes irq_async, counts rising edges and handshakes a non-nesting request with the handler.
module int_req_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int MAX_PEND    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_async,
  input  logic             int_en,
  input  logic             int_clear,
  input  logic             iret_done,
  input  logic             ovf_clr,
  output logic             int_req,
  output logic             in_service,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   sync_d;
  logic                   irq_edge;
  logic                   acc;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign irq_edge = sync_out & ~sync_d;
  assign acc      = int_clear & (state == REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
      sync_d <= sync_out;
    end
  end

  // A new edge and an accept in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (irq_edge && !acc) begin
        if (pend_cnt < PEND_MAX) pend_cnt <= pend_cnt + 1'b1;
      end else if (!irq_edge && acc) begin
        pend_cnt <= pend_cnt - 1'b1;
      end

      if (irq_edge && !acc && pend_cnt == PEND_MAX) ovf <= 1'b1;
      else if (ovf_clr)                             ovf <= 1'b0;
    end
  end

  // int_req and in_service are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_cnt != '0 && int_en) begin
            state   <= REQ;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          if (int_clear) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (!int_en) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (iret_done) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_req_ctrl.sv
// tb/tb_int_req_ctrl.sv - self-checking bench for int_req_ctrl
module tb_int_req_ctrl;
  localparam int S    = 2;
  localparam int W    = 3;
  localparam int MAXP = 7;

  logic         clk = 1'b0;
  logic         rst, irq_async, int_en, int_clear, iret_done, ovf_clr;
  logic         int_req, in_service, ovf;
  logic [W-1:0] pend_cnt;

  int total = 0;
  int bad   = 0;

  // Reference: queue of irq samples, integer pending count, phase 0=idle 1=requesting 2=serving.
  bit m_hist[$];
  int m_pend;
  bit m_ovf;
  int m_phase;

  int_req_ctrl #(.SYNC_STAGES(S), .CNT_W(W), .MAX_PEND(MAXP)) dut (
    .clk(clk), .rst(rst), .irq_async(irq_async), .int_en(int_en),
    .int_clear(int_clear), .iret_done(iret_done), .ovf_clr(ovf_clr),
    .int_req(int_req), .in_service(in_service), .pend_cnt(pend_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
    m_pend  = 0;
    m_ovf   = 1'b0;
    m_phase = 0;
  endtask

  task automatic tick();
    bit e, a, set_ovf;
    int old_pend;
    @(posedge clk);
    e        = m_hist[S-1] && !m_hist[S];
    a        = int_clear && (m_phase == 1);
    old_pend = m_pend;
    set_ovf  = e && !a && (old_pend == MAXP);
    if (e && !a && old_pend < MAXP) m_pend = old_pend + 1;
    if (!e && a)                    m_pend = old_pend - 1;
    m_ovf = set_ovf ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    case (m_phase)
      0: if (old_pend != 0 && int_en) m_phase = 1;
      1: if (int_clear) m_phase = 2; else if (!int_en) m_phase = 0;
      default: if (iret_done) m_phase = 0;
    endcase
    m_hist.push_front(irq_async);
    void'(m_hist.pop_back());
    #1;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      irq_async = 1'b1; tick(); tick();
      irq_async = 1'b0; tick(); tick();
    end
  endtask

  task automatic wait_int(output bit ok);
    for (int i = 0; i < 20 && !int_req; i++) tick();
    ok = int_req;
  endtask

  task automatic serve_once();
    bit ok;
    wait_int(ok);
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    iret_done = 1'b1; tick(); iret_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_async = 0; int_en = 0; int_clear = 0; iret_done = 0; ovf_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({int_req, in_service, pend_cnt, ovf} !== 6'b0) begin
      bad++; $display("FAIL reset_state act=%b req=000000", {int_req, in_service, pend_cnt, ovf});
    end
  endtask

  task automatic test_latency();
    int n = 0;
    int_en = 1'b1; irq_async = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) irq_async = 1'b0;
      if (int_req) begin n = i; break; end
    end
    irq_async = 1'b0;
    total++;
    if (n != 4) begin bad++; $display("FAIL latency act=%0d req=4", n); end
    total++;
    if (pend_cnt !== 3'd1) begin bad++; $display("FAIL latency_pend act=%0d req=1", pend_cnt); end
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b01000) begin
      bad++; $display("FAIL accept act=%b req=01000", {int_req, in_service, pend_cnt});
    end
    iret_done = 1'b1; tick(); iret_done = 1'b0;
    total++;
    if ({int_req, in_service} !== 2'b00) begin
      bad++; $display("FAIL iret act=%b req=00", {int_req, in_service});
    end
  endtask

  task automatic test_service_edges();
    bit ok;
    pulse(1);
    wait_int(ok);
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    pulse(3);
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b01011) begin
      bad++; $display("FAIL service_count act=%b req=01011", {int_req, in_service, pend_cnt});
    end
    iret_done = 1'b1; tick(); iret_done = 1'b0;
    total++;
    if ({int_req, in_service} !== 2'b00) begin
      bad++; $display("FAIL gap act=%b req=00", {int_req, in_service});
    end
    tick();
    total++;
    if (int_req !== 1'b1) begin bad++; $display("FAIL reassert act=%b req=1", int_req); end
    for (int r = 0; r < 3; r++) begin
      wait_int(ok);
      total++;
      if (!ok || pend_cnt !== 3'(3 - r)) begin
        bad++; $display("FAIL drain_req round=%0d int=%b pend=%0d req_pend=%0d", r, int_req, pend_cnt, 3 - r);
      end
      int_clear = 1'b1; tick(); int_clear = 1'b0;
      total++;
      if ({int_req, in_service, pend_cnt} !== {2'b01, 3'(2 - r)}) begin
        bad++; $display("FAIL drain_svc round=%0d act=%b req=01%03b", r, {int_req, in_service, pend_cnt}, 3'(2 - r));
      end
      iret_done = 1'b1; tick(); iret_done = 1'b0;
      tick();
    end
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b0) begin
      bad++; $display("FAIL drained act=%b req=00000", {int_req, in_service, pend_cnt});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse(9);
    total++;
    if ({int_req, pend_cnt, ovf} !== 5'b01111) begin
      bad++; $display("FAIL saturate act=%b req=01111", {int_req, pend_cnt, ovf});
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr act=%b req=0", ovf); end
    irq_async = 1'b1; tick(); tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++;
    if ({pend_cnt, ovf} !== 4'b1111) begin
      bad++; $display("FAIL set_wins act=%b req=1111", {pend_cnt, ovf});
    end
    irq_async = 1'b0; tick(); tick();
  endtask

  task automatic test_edge_and_clear();
    do_reset();
    pulse(2);
    int_en = 1'b1; tick();
    irq_async = 1'b1; tick(); tick();
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    irq_async = 1'b0;
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b01010) begin
      bad++; $display("FAIL edge_clear act=%b req=01010", {int_req, in_service, pend_cnt});
    end
    iret_done = 1'b1; tick(); iret_done = 1'b0;
  endtask

  task automatic test_en_drop();
    do_reset();
    pulse(2);
    int_en = 1'b1; tick();
    int_en = 1'b0; int_clear = 1'b1; tick(); int_clear = 1'b0; int_en = 1'b1;
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b01001) begin
      bad++; $display("FAIL clear_beats_en act=%b req=01001", {int_req, in_service, pend_cnt});
    end
    iret_done = 1'b1; tick(); iret_done = 1'b0;
    tick();
    int_en = 1'b0; tick(); tick();
    total++;
    if ({int_req, in_service, pend_cnt} !== 5'b00001) begin
      bad++; $display("FAIL withdraw act=%b req=00001", {int_req, in_service, pend_cnt});
    end
    int_en = 1'b1; tick();
    total++;
    if (int_req !== 1'b1) begin bad++; $display("FAIL en_return act=%b req=1", int_req); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    pulse(8);
    int_en = 1'b1;
    serve_once(); serve_once();
    wait_int(ok);
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    total++;
    if ({in_service, pend_cnt, ovf} !== 5'b11001) begin
      bad++; $display("FAIL pre_reset act=%b req=11001", {in_service, pend_cnt, ovf});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({int_req, in_service, pend_cnt, ovf} !== 6'b0) begin
      bad++; $display("FAIL async_reset act=%b req=000000", {int_req, in_service, pend_cnt, ovf});
    end
    #1 rst = 1'b0;
    model_reset();
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    iret_done = 1'b1; tick(); iret_done = 1'b0;
    tick();
    total++;
    if ({int_req, in_service, pend_cnt, ovf} !== 6'b0) begin
      bad++; $display("FAIL spurious act=%b req=000000", {int_req, in_service, pend_cnt, ovf});
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) irq_async = ~irq_async;
      int_en    = ($urandom_range(7) != 0);
      int_clear = ($urandom_range(2) == 0);
      iret_done = ($urandom_range(3) == 0);
      ovf_clr   = ($urandom_range(15) == 0);
      tick();
      exp_v = {m_phase == 1, m_phase == 2, 3'(m_pend), m_ovf};
      total++;
      if ({int_req, in_service, pend_cnt, ovf} !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d act=%b req=%b", i, {int_req, in_service, pend_cnt, ovf}, exp_v);
      end
    end
    int_clear = 0; iret_done = 0; ovf_clr = 0; irq_async = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_service_edges();
    test_saturation();
    test_edge_and_clear();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
